// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;

    // addi x0, x0, 0 -- presented to decode whenever no entry is valid
    localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_instr_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage.
module instr_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * WORD_W,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           headData,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    // Pop on empty is ignored; a push into a full FIFO only lands alongside a pop.
    assign doPop  = pop && (count != '0);
    assign doPush = push && ((count != CNT_W'(DEPTH)) || doPop);

    assign headData = mem[rdPtr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            if (doPush && !doPop)      count <= count + CNT_W'(1);
            else if (doPop && !doPush) count <= count - CNT_W'(1);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end

endmodule : instr_fifo

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order response buffering, redirect flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     WORD     = WORD_W,
    parameter int unsigned     DEPTH    = DEPTH_DEFAULT,
    parameter logic [WORD-1:0] RESET_PC = WORD'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imemReqValid,
    output logic [WORD-1:0] imemReqAddr,
    input  logic            imemReqReady,
    input  logic            imemRespValid,
    input  logic [WORD-1:0] imemRespData,
    input  logic            redirect,
    input  logic [WORD-1:0] redirectPC,
    output logic            instrValidD,
    output logic [WORD-1:0] pcD,
    output logic [WORD-1:0] instrD,
    input  logic            decodeReady
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WORD-1:0]   pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  addrCount;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  dropCnt;
    logic [CNT_W:0]    occupancy;
    logic [WORD-1:0]   addrHead;
    logic [2*WORD-1:0] entryHead;
    logic              fire;
    logic              respKeep;
    logic              popHead;
    logic              unusedRedirectLsbs;

    assign unusedRedirectLsbs = ^redirectPC[1:0];

    // Credit: buffered plus outstanding never exceeds DEPTH, so the FIFO cannot overflow.
    assign occupancy    = {1'b0, count} + {1'b0, inflight};
    assign imemReqValid = !redirect && (occupancy < (CNT_W + 1)'(DEPTH));
    assign imemReqAddr  = pc;
    assign fire         = imemReqValid && imemReqReady;

    // A response is kept only when nothing is pending drop and no redirect is flushing.
    assign respKeep = imemRespValid && (dropCnt == '0) && !redirect && (addrCount != '0);

    // Head presentation; redirect hides the head and blocks the pop.
    assign instrValidD = !redirect && (count != '0);
    assign popHead     = instrValidD && decodeReady;
    assign pcD         = instrValidD ? entryHead[2*WORD-1:WORD] : '0;
    assign instrD      = instrValidD ? entryHead[WORD-1:0] : WORD'(NOP_INSTR);

    // Fetch PC: redirect reloads word-aligned target, an accepted request advances by 4.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {redirectPC[WORD-1:2], 2'b00};
        end else if (fire) begin
            pc <= pc + WORD'(4);
        end
    end

    // Outstanding and drop counters; on redirect every still-outstanding response is marked for drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
            dropCnt  <= '0;
        end else if (redirect) begin
            inflight <= inflight - CNT_W'(imemRespValid);
            dropCnt  <= inflight - CNT_W'(imemRespValid);
        end else begin
            inflight <= inflight + CNT_W'(fire) - CNT_W'(imemRespValid);
            if (imemRespValid && (dropCnt != '0)) dropCnt <= dropCnt - CNT_W'(1);
        end
    end

    // Address of each live request, consumed by its response.
    instr_fifo #(
        .WIDTH (WORD),
        .DEPTH (DEPTH)
    ) u_addrFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fire),
        .pushData (pc),
        .pop      (respKeep),
        .flush    (redirect),
        .headData (addrHead),
        .count    (addrCount)
    );

    // Decode-facing {pc, instr} buffer.
    instr_fifo #(
        .WIDTH (2 * WORD),
        .DEPTH (DEPTH)
    ) u_instrFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (respKeep),
        .pushData ({addrHead, imemRespData}),
        .pop      (popHead),
        .flush    (redirect),
        .headData (entryHead),
        .count    (count)
    );

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency in-order memory model.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hA500_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        instrValidD;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        decodeReady;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;

    logic [31:0] memQ[$];
    int          dueQ[$];

    fetch_queue #(
        .WORD     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imemReqValid  (imemReqValid),
        .imemReqAddr   (imemReqAddr),
        .imemReqReady  (imemReqReady),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .redirect      (redirect),
        .redirectPC    (redirectPC),
        .instrValidD   (instrValidD),
        .pcD           (pcD),
        .instrD        (instrD),
        .decodeReady   (decodeReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive the memory response for the current cycle and let outputs settle.
    task automatic settle();
        if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
            imemRespValid = 1'b1;
            imemRespData  = memQ[0] ^ KEY;
        end else begin
            imemRespValid = 1'b0;
            imemRespData  = '0;
        end
        #1;
    endtask

    // Capture handshakes, clock once, update the memory model.
    task automatic advance();
        logic        fire;
        logic        resp;
        logic [31:0] addr;
        fire = imemReqValid && imemReqReady;
        resp = imemRespValid;
        addr = imemReqAddr;
        @(posedge clk);
        if (resp) begin
            void'(memQ.pop_front());
            void'(dueQ.pop_front());
        end
        if (fire) begin
            memQ.push_back(addr);
            dueQ.push_back(cyc + lat);
        end
        @(negedge clk);
        cyc++;
        redirect = 1'b0;
    endtask

    task automatic doReset();
        reset         = 1'b0;
        redirect      = 1'b0;
        redirectPC    = '0;
        imemRespValid = 1'b0;
        imemRespData  = '0;
        memQ.delete();
        dueQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic checkHead(input string tag, input logic [31:0] pcExp);
        check({tag, " valid"}, 32'(instrValidD), 32'd1);
        check({tag, " pc"}, pcD, pcExp);
        check({tag, " instr"}, instrD, pcExp ^ KEY);
    endtask

    initial begin
        reset        = 1'b0;
        imemReqReady = 1'b1;
        decodeReady  = 1'b1;
        redirect     = 1'b0;
        redirectPC   = '0;

        // Streaming, L=1: one request and one delivery per cycle.
        lat = 1; imemReqReady = 1'b1; decodeReady = 1'b1;
        doReset();
        for (int k = 0; k < 10; k++) begin
            settle();
            if (k == 0) begin
                check("rst instrD", instrD, NOP);
                check("rst pcD", pcD, 32'h0);
            end
            check($sformatf("s1 reqv c%0d", k), 32'(imemReqValid), 32'd1);
            check($sformatf("s1 addr c%0d", k), imemReqAddr, 32'(4 * k));
            if (k < 2) check($sformatf("s1 iv c%0d", k), 32'(instrValidD), 32'd0);
            else       checkHead($sformatf("s1 c%0d", k), 32'(4 * (k - 2)));
            advance();
        end

        // Decode stalled: exactly DEPTH requests, then drain in order and resume.
        doReset();
        decodeReady = 1'b0;
        for (int k = 0; k < 13; k++) begin
            decodeReady = (k >= 8);
            settle();
            if (k < 4) begin
                check($sformatf("s2 reqv c%0d", k), 32'(imemReqValid), 32'd1);
                check($sformatf("s2 addr c%0d", k), imemReqAddr, 32'(4 * k));
            end else if (k <= 8) begin
                check($sformatf("s2 stall c%0d", k), 32'(imemReqValid), 32'd0);
            end else if (k == 9) begin
                check("s2 resume reqv", 32'(imemReqValid), 32'd1);
                check("s2 resume addr", imemReqAddr, 32'h10);
            end
            if (k == 7) checkHead("s2 full", 32'h0);
            if (k >= 8) checkHead($sformatf("s2 pop c%0d", k), 32'(4 * (k - 8)));
            advance();
        end

        // Memory back-pressure at 0x10: address held, no duplicates.
        decodeReady = 1'b1;
        doReset();
        for (int k = 0; k < 11; k++) begin
            imemReqReady = !(k >= 4 && k <= 6);
            settle();
            if (k <= 3)      check($sformatf("s3 addr c%0d", k), imemReqAddr, 32'(4 * k));
            else if (k <= 7) begin
                check($sformatf("s3 hold v c%0d", k), 32'(imemReqValid), 32'd1);
                check($sformatf("s3 hold a c%0d", k), imemReqAddr, 32'h10);
            end else if (k == 8) check("s3 next addr", imemReqAddr, 32'h14);
            if (k >= 2 && k <= 5)      checkHead($sformatf("s3 c%0d", k), 32'(4 * (k - 2)));
            else if (k >= 6 && k <= 8) check($sformatf("s3 gap c%0d", k), 32'(instrValidD), 32'd0);
            else if (k >= 9)           checkHead($sformatf("s3 c%0d", k), 32'(32'h10 + 4 * (k - 9)));
            advance();
        end
        imemReqReady = 1'b1;

        // L=3, redirect with 3 in flight: stale responses dropped, low bits ignored.
        lat = 3;
        doReset();
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                redirect   = 1'b1;
                redirectPC = 32'h0000_0103;
            end
            settle();
            if (k < 3)  check($sformatf("s4 addr c%0d", k), imemReqAddr, 32'(4 * k));
            if (k == 3) check("s4 redir reqv", 32'(imemReqValid), 32'd0);
            if (k >= 4 && k <= 7) check($sformatf("s4 addr c%0d", k), imemReqAddr, 32'(32'h100 + 4 * (k - 4)));
            if (k >= 3 && k <= 7) check($sformatf("s4 iv c%0d", k), 32'(instrValidD), 32'd0);
            if (k >= 8) checkHead($sformatf("s4 c%0d", k), 32'(32'h100 + 4 * (k - 8)));
            advance();
        end

        // L=2, redirect on response+pop, then second redirect: only 0x200 path delivered.
        lat = 2;
        doReset();
        for (int k = 0; k < 11; k++) begin
            if (k == 4) begin redirect = 1'b1; redirectPC = 32'h100; end
            if (k == 5) begin redirect = 1'b1; redirectPC = 32'h200; end
            settle();
            if (k == 3) checkHead("s5 pre", 32'h0);
            if (k == 4) begin
                check("s5 r1 resp", 32'(imemRespValid), 32'd1);
                check("s5 r1 iv", 32'(instrValidD), 32'd0);
                check("s5 r1 reqv", 32'(imemReqValid), 32'd0);
            end
            if (k == 5) check("s5 r2 reqv", 32'(imemReqValid), 32'd0);
            if (k == 6) check("s5 new addr", imemReqAddr, 32'h200);
            if (k >= 5 && k <= 8) check($sformatf("s5 iv c%0d", k), 32'(instrValidD), 32'd0);
            if (k >= 9) checkHead($sformatf("s5 c%0d", k), 32'(32'h200 + 4 * (k - 9)));
            advance();
        end

        // Async reset with a full queue: outputs clear immediately, fetch restarts at RESET_PC.
        lat = 1; decodeReady = 1'b0;
        doReset();
        for (int k = 0; k < 6; k++) begin
            settle();
            advance();
        end
        settle();
        checkHead("s6 full", 32'h0);
        check("s6 full reqv", 32'(imemReqValid), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("s6 async iv", 32'(instrValidD), 32'd0);
        check("s6 async instr", instrD, NOP);
        check("s6 async pc", pcD, 32'h0);
        check("s6 async addr", imemReqAddr, 32'h0);
        decodeReady = 1'b1;
        doReset();
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("s6 addr c%0d", k), imemReqAddr, 32'(4 * k));
            if (k < 2) check($sformatf("s6 iv c%0d", k), 32'(instrValidD), 32'd0);
            else       checkHead($sformatf("s6 c%0d", k), 32'(4 * (k - 2)));
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_queue
